// File: rtl/mcu_cmd_router_pkg.sv
// Shared types and constants for the MCU command router.
package mcu_cmd_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_FORWARD,
    ST_DISCARD
  } router_state_t;

  localparam logic [7:0] DOUT_IDLE = 8'hFF;

  localparam logic [3:0] TGT_HID = 4'd0;
  localparam logic [3:0] TGT_OSD = 4'd1;
  localparam logic [3:0] TGT_SDC = 4'd2;
  localparam logic [3:0] TGT_SYS = 4'd3;

  localparam int WDOG_W = 16;

endpackage

// File: rtl/mcu_cmd_router_wdog.sv
// Idle-cycle watchdog for the MCU command router: counts clocks without a
// strobe while a frame is open and flags expiry at TIMEOUT_CYCLES.
module mcu_cmd_router_wdog
  import mcu_cmd_router_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic idle,
  output logic expire
);

  logic [WDOG_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || strobe || idle) count <= '0;
    else                         count <= count + 1'b1;
  end

  // A strobe on the expiry cycle restarts the count instead of aborting.
  assign expire = (count == WDOG_W'(TIMEOUT_CYCLES)) && !strobe && !idle;

endmodule

// File: rtl/mcu_cmd_router.sv
// Routes MCU frames to one of NUM_TARGETS consumers by a leading select byte.
// Optional frame watchdog enabled by defining MCU_CMD_ROUTER_TIMEOUT_EN.
module mcu_cmd_router
  import mcu_cmd_router_pkg::*;
#(
  parameter int NUM_TARGETS    = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mcu_strobe,
  input  logic                     mcu_start,
  input  logic [7:0]               mcu_din,
  output logic [7:0]               mcu_dout,
  output logic [NUM_TARGETS-1:0]   tgt_strobe,
  output logic                     tgt_start,
  output logic [7:0]               tgt_din,
  input  logic [8*NUM_TARGETS-1:0] tgt_dout,
  output logic [3:0]               active_tgt,
  output logic                     busy,
  output logic                     bad_target,
  output logic                     timeout
);

  if (NUM_TARGETS < 1 || NUM_TARGETS > 16) begin : g_bad_num_targets
    $error("mcu_cmd_router: NUM_TARGETS out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mcu_cmd_router: TIMEOUT_CYCLES out of range");
  end

  localparam logic [4:0] NT = 5'(NUM_TARGETS);

  router_state_t          state, state_d;
  logic                   start_evt, data_evt, sel_ok, expire;
  logic                   fwd, fwd_first;
  logic [NUM_TARGETS-1:0] strobe_d;
  logic [7:0]             ret_byte;

  assign start_evt = mcu_strobe && mcu_start;
  assign data_evt  = mcu_strobe && !mcu_start;
  assign sel_ok    = {1'b0, mcu_din[3:0]} < NT;
  assign busy      = (state != ST_IDLE);

`ifdef MCU_CMD_ROUTER_TIMEOUT_EN
  mcu_cmd_router_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .strobe(mcu_strobe),
    .idle  (state == ST_IDLE),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // A start byte overrides everything, including a coincident watchdog expiry.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state;
    if (start_evt)                            state_d = sel_ok ? ST_HEADER : ST_DISCARD;
    else if (expire)                          state_d = ST_IDLE;
    else if (data_evt && state == ST_HEADER)  state_d = ST_FORWARD;
  end

  always_comb begin
    fwd       = data_evt && (state == ST_HEADER || state == ST_FORWARD);
    fwd_first = (state == ST_HEADER);
    strobe_d  = '0;
    ret_byte  = DOUT_IDLE;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      strobe_d[k] = fwd && (active_tgt == 4'(k));
      if ((state == ST_HEADER || state == ST_FORWARD) && active_tgt == 4'(k))
        ret_byte = tgt_dout[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_strobe <= '0;
      tgt_start  <= 1'b0;
      tgt_din    <= 8'h00;
      mcu_dout   <= DOUT_IDLE;
      active_tgt <= TGT_HID;
      bad_target <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      tgt_strobe <= strobe_d;
      tgt_start  <= fwd && fwd_first;
      if (fwd) tgt_din <= mcu_din;
      mcu_dout   <= ret_byte;
      if (start_evt && sel_ok) active_tgt <= mcu_din[3:0];
      bad_target <= start_evt && !sel_ok;
      timeout    <= expire;
    end
  end

endmodule

// File: tb/tb_mcu_cmd_router.sv
// Self-checking bench for mcu_cmd_router: per-cycle vector table plus
// watchdog sequences (behaviour depends on MCU_CMD_ROUTER_TIMEOUT_EN).
module tb_mcu_cmd_router;
  import mcu_cmd_router_pkg::*;

  localparam int NT = 4;
`ifdef MCU_CMD_ROUTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65535;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mcu_strobe = 1'b0;
  logic          mcu_start = 1'b0;
  logic [7:0]    mcu_din = 8'h00;
  logic [7:0]    mcu_dout;
  logic [NT-1:0] tgt_strobe;
  logic          tgt_start;
  logic [7:0]    tgt_din;
  logic [8*NT-1:0] tgt_dout = {8'hA3, 8'h5C, 8'hA1, 8'hA0};
  logic [3:0]    active_tgt;
  logic          busy, bad_target, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  mcu_cmd_router #(.NUM_TARGETS(NT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mcu_strobe(mcu_strobe), .mcu_start(mcu_start),
    .mcu_din(mcu_din), .mcu_dout(mcu_dout), .tgt_strobe(tgt_strobe),
    .tgt_start(tgt_start), .tgt_din(tgt_din), .tgt_dout(tgt_dout),
    .active_tgt(active_tgt), .busy(busy), .bad_target(bad_target), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, stb, st;
    logic [7:0] din;
    logic [3:0] e_stb;
    logic       e_start;
    logic [7:0] e_din, e_dout;
    logic [3:0] e_act;
    logic       e_busy, e_bad;
  } vec_t;

  function automatic vec_t v(input logic rst, stb, st, input logic [7:0] din,
                             input logic [3:0] es, input logic est, input logic [7:0] ed,
                             input logic [7:0] edout, input logic [3:0] ea,
                             input logic eb, ebad);
    vec_t r;
    r.rst = rst; r.stb = stb; r.st = st; r.din = din;
    r.e_stb = es; r.e_start = est; r.e_din = ed; r.e_dout = edout;
    r.e_act = ea; r.e_busy = eb; r.e_bad = ebad;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then sample 1 time unit later.
  task automatic drive(input logic rst, stb, st, input logic [7:0] din);
    reset = rst; mcu_strobe = stb; mcu_start = st; mcu_din = din;
    @(posedge clk);
    #1;
    reset = 1'b0; mcu_strobe = 1'b0; mcu_start = 1'b0; mcu_din = 8'h00;
  endtask

  vec_t vecs[27];
  int   pulses;

  initial begin
    //            rst stb st din    e_stb  est e_din  e_dout act busy bad
    vecs[0]  = v(1, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 8'hFF, 0, 0, 0);
    vecs[1]  = v(0, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 8'hFF, 0, 0, 0);
    vecs[2]  = v(0, 1, 1, 8'h00, 4'b0000, 0, 8'h00, 8'hFF, 0, 1, 0);
    vecs[3]  = v(0, 1, 0, 8'h01, 4'b0001, 1, 8'h01, 8'hA0, 0, 1, 0);
    vecs[4]  = v(0, 1, 0, 8'h8A, 4'b0001, 0, 8'h8A, 8'hA0, 0, 1, 0);
    vecs[5]  = v(0, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 8'hA0, 0, 1, 0);
    vecs[6]  = v(0, 1, 1, 8'h02, 4'b0000, 0, 8'h00, 8'hA0, 2, 1, 0);
    vecs[7]  = v(0, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 8'h5C, 2, 1, 0);
    vecs[8]  = v(0, 1, 1, 8'h09, 4'b0000, 0, 8'h00, 8'h5C, 2, 1, 1);
    vecs[9]  = v(0, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 8'hFF, 2, 1, 0);
    vecs[10] = v(0, 1, 1, 8'h01, 4'b0000, 0, 8'h00, 8'hFF, 1, 1, 0);
    vecs[11] = v(0, 1, 0, 8'h33, 4'b0010, 1, 8'h33, 8'hA1, 1, 1, 0);
    vecs[12] = v(0, 1, 0, 8'h44, 4'b0010, 0, 8'h44, 8'hA1, 1, 1, 0);
    vecs[13] = v(0, 1, 1, 8'h03, 4'b0000, 0, 8'h00, 8'hA1, 3, 1, 0);
    vecs[14] = v(0, 1, 0, 8'h10, 4'b1000, 1, 8'h10, 8'hA3, 3, 1, 0);
    vecs[15] = v(0, 1, 0, 8'h11, 4'b1000, 0, 8'h11, 8'hA3, 3, 1, 0);
    vecs[16] = v(0, 1, 1, 8'h07, 4'b0000, 0, 8'h00, 8'hA3, 3, 1, 1);
    vecs[17] = v(0, 1, 0, 8'h55, 4'b0000, 0, 8'h00, 8'hFF, 3, 1, 0);
    vecs[18] = v(0, 1, 0, 8'h66, 4'b0000, 0, 8'h00, 8'hFF, 3, 1, 0);
    vecs[19] = v(0, 1, 0, 8'h77, 4'b0000, 0, 8'h00, 8'hFF, 3, 1, 0);
    vecs[20] = v(0, 0, 0, 8'h00, 4'b0000, 0, 8'h00, 8'hFF, 3, 1, 0);
    vecs[21] = v(0, 1, 1, 8'h00, 4'b0000, 0, 8'h00, 8'hFF, 0, 1, 0);
    vecs[22] = v(0, 1, 0, 8'h21, 4'b0001, 1, 8'h21, 8'hA0, 0, 1, 0);
    vecs[23] = v(1, 1, 0, 8'h22, 4'b0000, 0, 8'h00, 8'hFF, 0, 0, 0);
    vecs[24] = v(0, 1, 0, 8'h23, 4'b0000, 0, 8'h00, 8'hFF, 0, 0, 0);
    vecs[25] = v(0, 1, 1, 8'h12, 4'b0000, 0, 8'h00, 8'hFF, 2, 1, 0);
    vecs[26] = v(0, 1, 0, 8'h34, 4'b0100, 1, 8'h34, 8'h5C, 2, 1, 0);

    #1;
    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].rst, vecs[i].stb, vecs[i].st, vecs[i].din);
      check($sformatf("row%0d.tgt_strobe", i), 32'(tgt_strobe), 32'(vecs[i].e_stb));
      check($sformatf("row%0d.tgt_start", i),  32'(tgt_start),  32'(vecs[i].e_start));
      if (vecs[i].e_stb != 4'b0000 || vecs[i].rst)
        check($sformatf("row%0d.tgt_din", i),  32'(tgt_din),    32'(vecs[i].e_din));
      check($sformatf("row%0d.mcu_dout", i),   32'(mcu_dout),   32'(vecs[i].e_dout));
      check($sformatf("row%0d.active_tgt", i), 32'(active_tgt), 32'(vecs[i].e_act));
      check($sformatf("row%0d.busy", i),       32'(busy),       32'(vecs[i].e_busy));
      check($sformatf("row%0d.bad_target", i), 32'(bad_target), 32'(vecs[i].e_bad));
      check($sformatf("row%0d.timeout", i),    32'(timeout),    32'd0);
    end

`ifdef MCU_CMD_ROUTER_TIMEOUT_EN
    // Stall in HEADER: expiry lands on the 17th idle edge (count reached 16).
    drive(0, 1, 1, 8'h01);
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      drive(0, 0, 0, 8'h00);
      pulses += int'(timeout);
    end
    check("wd_no_early_timeout", 32'(pulses), 32'd0);
    drive(0, 0, 0, 8'h00);
    check("wd_timeout_pulse", 32'(timeout), 32'd1);
    check("wd_busy_drops", 32'(busy), 32'd0);
    drive(0, 0, 0, 8'h00);
    check("wd_timeout_single", 32'(timeout), 32'd0);
    drive(0, 1, 0, 8'h77);
    check("wd_post_ignored_strobe", 32'(tgt_strobe), 32'd0);
    check("wd_post_ignored_busy", 32'(busy), 32'd0);

    // Strobe exactly at count 16 wins over the watchdog.
    drive(0, 1, 1, 8'h01);
    for (int c = 0; c < 16; c++) drive(0, 0, 0, 8'h00);
    drive(0, 1, 0, 8'h5A);
    check("wd_race_no_timeout", 32'(timeout), 32'd0);
    check("wd_race_forward", 32'(tgt_strobe), 32'b0010);
    check("wd_race_start", 32'(tgt_start), 32'd1);
    check("wd_race_din", 32'(tgt_din), 32'h5A);
    drive(0, 0, 0, 8'h00);
    check("wd_race_still_busy", 32'(busy), 32'd1);
    check("wd_race_no_late_timeout", 32'(timeout), 32'd0);
`else
    // Without the watchdog a stalled frame stays open indefinitely.
    drive(0, 1, 1, 8'h01);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 0, 0, 8'h00);
      pulses += int'(timeout);
    end
    check("nowd_no_timeout", 32'(pulses), 32'd0);
    check("nowd_still_busy", 32'(busy), 32'd1);
    drive(0, 1, 0, 8'h42);
    check("nowd_forward_after_gap", 32'(tgt_strobe), 32'b0010);
    check("nowd_forward_start", 32'(tgt_start), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcu_cmd_router.md
# mcu_cmd_router

Byte-stream router between the IO MCU link and the on-chip MCU command consumers: `hid`, OSD, SD-card and system-control blocks. Each MCU frame starts with a target-select byte. The router forwards the rest of the frame, with re-generated start framing, to exactly one target. It returns that target's `data_out` to the MCU and discards frames for unknown targets. An optional watchdog aborts frames that stall mid-transfer.

## Interface
Parameters:
- `NUM_TARGETS`, 4: number of downstream consumers (1..16). Target 0 is `hid`.
- `TIMEOUT_CYCLES`, 65535: idle clocks inside a frame before the watchdog aborts it (1..65535).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `mcu_strobe`  in  1  one-cycle pulse, `mcu_din` valid
- `mcu_start`  in  1  qualifies `mcu_strobe`: first byte of a frame
- `mcu_din`  in  8  byte from MCU
- `mcu_dout`  out  8  byte returned to MCU (registered)
- `tgt_strobe`  out  NUM_TARGETS  one-hot forwarded strobe
- `tgt_start`  out  1  start flag accompanying `tgt_strobe`
- `tgt_din`  out  8  forwarded byte, shared by all targets
- `tgt_dout`  in  8*NUM_TARGETS  target return bytes; target k occupies bits [8k+7:8k]
- `active_tgt`  out  4  currently selected target id
- `busy`  out  1  frame in progress (state is not IDLE)
- `bad_target`  out  1  one-cycle pulse when a select byte has id >= NUM_TARGETS
- `timeout`  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, HEADER, FORWARD, DISCARD.
- A strobe with `mcu_start=1`, in any state:
  - latch `sel = mcu_din[3:0]`;
  - if `sel < NUM_TARGETS`, go to HEADER;
  - otherwise go to DISCARD and pulse `bad_target`.
  - The select byte is never forwarded. A start received mid-frame aborts the current frame silently.
- HEADER, strobe with `mcu_start=0`: forward the byte with `tgt_start=1`, then go to FORWARD. This byte is the target's command byte.
- FORWARD, strobe with `mcu_start=0`: forward the byte with `tgt_start=0`. The state is unchanged; frames have unbounded length.
- DISCARD: strobes with `mcu_start=0` are swallowed and no `tgt_strobe` is raised.
- IDLE: strobes with `mcu_start=0` are ignored.
- `mcu_dout` is registered every clk:
  - HEADER/FORWARD: `tgt_dout[sel]`;
  - IDLE/DISCARD: 8'hFF.
- `active_tgt` holds `sel`. It keeps its last value through IDLE and DISCARD, and an invalid id is not loaded.
- Reset values:
  - state IDLE;
  - `tgt_strobe` 0, `tgt_start` 0, `tgt_din` 8'h00;
  - `mcu_dout` 8'hFF;
  - `active_tgt` 0, `busy` 0, `bad_target` 0, `timeout` 0;
  - watchdog counter 0.

## Timing
- Forward latency is 1 clk. `mcu_strobe` at edge N produces `tgt_strobe`, `tgt_start` and `tgt_din` at edge N+1, high for exactly one cycle.
- The `mcu_dout` selection change takes effect 1 clk after the state change.
- Back-to-back strobes every cycle are supported, with no stalls and no dropped bytes.
- Reset mid-frame: at the next edge all outputs take their reset values. No partial `tgt_strobe` is emitted after that edge.
- `bad_target` and `timeout` pulse at the same edge as the corresponding state change.

## Configuration
- Macro `MCU_CMD_ROUTER_TIMEOUT_EN`.
- Defined:
  - a 16-bit counter clears on every `mcu_strobe` and in IDLE, and increments in other states;
  - when the count reaches `TIMEOUT_CYCLES`, go to IDLE and pulse `timeout`;
  - a strobe arriving on that same cycle wins: the counter clears and there is no timeout.
- Not defined: no counter is built, `timeout` is tied to 0, and a frame ends only by a new start or by reset.

## Structure
- `mcu_cmd_router_pkg` holds:
  - the state enum `router_state_t`;
  - `DOUT_IDLE = 8'hFF`;
  - the target id constants `TGT_HID = 0`, `TGT_OSD = 1`, `TGT_SDC = 2`, `TGT_SYS = 3`.
- One sub-module, `mcu_cmd_router_wdog`: the counter plus its compare. It is instantiated only under `MCU_CMD_ROUTER_TIMEOUT_EN`.

## Test plan
- Normal frame:
  - stimulus: strobes with start=1 din=8'h00, then din=8'h01 and din=8'h8A;
  - response: `tgt_strobe` is 4'b0001 twice, first with `tgt_start=1` din=8'h01, then with `tgt_start=0` din=8'h8A, each 1 clk after its MCU strobe.
- Return path:
  - stimulus: select target 2 with `tgt_dout[23:16]=8'h5C`;
  - response: `mcu_dout` reads 8'h5C one clk after entering HEADER, and reads 8'hFF after a later start to id 9.
- Bad target:
  - stimulus: start byte 8'h07 with NUM_TARGETS=4, then 3 payload bytes;
  - response: one `bad_target` pulse, no `tgt_strobe`, `mcu_dout` 8'hFF, `active_tgt` unchanged.
- Mid-frame restart:
  - stimulus: target 1 frame with 2 bytes forwarded, then start=1 din=8'h03, then din=8'h10;
  - response: din=8'h10 goes to target 3 with `tgt_start=1`, and target 1 receives nothing further.
- Watchdog, macro defined, TIMEOUT_CYCLES=16:
  - stimulus: HEADER then a 16-clk gap;
  - response: `timeout` pulses once, `busy` drops, and a later non-start byte is ignored.
  - Repeat with a strobe exactly at count 16: no timeout.
- Reset mid-frame:
  - stimulus: assert reset on the same edge as a strobe during FORWARD;
  - response: no `tgt_strobe` at the next edge, and all outputs at reset values.
